// File: rtl/rtsnoc_bridge_pkg.sv
// rtl/rtsnoc_bridge_pkg.sv - shared widths, field offsets and FSM encodings for the RTSNoC achannel bridge
package rtsnoc_bridge_pkg;

    // Each address field in an achannel message occupies one byte.
    localparam int ADDR_BYTE_W = 8;
    // The local-port field is always 3 bits on the NoC side.
    localparam int LOCAL_W     = 3;
    // Zero-extension width for the local field in an achannel byte.
    localparam int LOCAL_DIFF  = ADDR_BYTE_W - LOCAL_W;

    // Offsets of the address bytes above the data field in an achannel message.
    localparam int MSG_X_OFS = 0;
    localparam int MSG_Y_OFS = ADDR_BYTE_W;
    localparam int MSG_L_OFS = 2 * ADDR_BYTE_W;

    // Two-state strobe FSM used on every handshake side.
    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_STROBE = 1'b1;

    // NoC flit width: data plus origin and destination {X,Y,local}.
    function automatic int bus_width(input int size_x, input int size_y, input int size_data);
        return size_data + 2 * size_x + 2 * size_y + 2 * LOCAL_W;
    endfunction

    // Zero-extension width of a mesh coordinate into an achannel byte.
    function automatic int size_diff(input int size_w);
        return ADDR_BYTE_W - size_w;
    endfunction

endpackage

// File: rtl/rtsnoc_sync_fifo.sv
// rtl/rtsnoc_sync_fifo.sv - synchronous FIFO with registered read-first output
// Ports: clk_i/rst_i (sync active-high), push/wdata, pop, full, empty, rdata.
// rdata is loaded from the head entry on the edge that pops it and then holds.
// A push while full is accepted only if a pop happens on the same edge; a pop
// while empty is ignored, so an empty FIFO never passes data straight through.
module rtsnoc_sync_fifo #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] rdata
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wptr;
    logic [DEPTH_LOG2-1:0] rptr;
    logic [DEPTH_LOG2:0]   count;
    logic                  do_push;
    logic                  do_pop;

    // count never exceeds DEPTH, so its MSB alone marks the full state.
    assign full    = count[DEPTH_LOG2];
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[wptr] <= wdata;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            rdata <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + 1'b1;
            end
            if (do_pop) begin
                rdata <= mem[rptr];
                rptr  <= rptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/rtsnoc_achannel_bridge.sv
// rtl/rtsnoc_achannel_bridge.sv - buffered bridge between an RTSNoC local port and RMI achannels
// Ports: clk_i/rst_i (sync active-high); router side din_o/wr_o/wait_i, dout_i/nd_i/rd_o;
// own address x/y/local_addr; achannel TX tx_ch_z_i/tx_ch_lz_i/tx_ch_vz_o;
// achannel RX rx_ch_z_o/rx_ch_lz_i/rx_ch_vz_o; drop_cnt_o counts filtered packets.
module rtsnoc_achannel_bridge
    import rtsnoc_bridge_pkg::*;
#(
    parameter int SIZE_X        = 1,
    parameter int SIZE_Y        = 1,
    parameter int SIZE_DATA     = 56,
    parameter int RMI_MSG_SIZE  = 80,
    parameter int TX_DEPTH_LOG2 = 2,
    parameter int RX_DEPTH_LOG2 = 2,
    parameter bit CHECK_DST     = 1'b0
) (
    input  logic                                           clk_i,
    input  logic                                           rst_i,
    output logic [bus_width(SIZE_X, SIZE_Y, SIZE_DATA)-1:0] din_o,
    output logic                                           wr_o,
    input  logic                                           wait_i,
    input  logic [bus_width(SIZE_X, SIZE_Y, SIZE_DATA)-1:0] dout_i,
    input  logic                                           nd_i,
    output logic                                           rd_o,
    input  logic [SIZE_X-1:0]                              x,
    input  logic [SIZE_Y-1:0]                              y,
    input  logic [LOCAL_W-1:0]                             local_addr,
    input  logic [RMI_MSG_SIZE-1:0]                        tx_ch_z_i,
    input  logic                                           tx_ch_lz_i,
    output logic                                           tx_ch_vz_o,
    output logic [RMI_MSG_SIZE-1:0]                        rx_ch_z_o,
    input  logic                                           rx_ch_lz_i,
    output logic                                           rx_ch_vz_o,
    output logic [15:0]                                    drop_cnt_o
);

    localparam int BUS     = bus_width(SIZE_X, SIZE_Y, SIZE_DATA);
    localparam int ADDR_W  = SIZE_X + SIZE_Y + LOCAL_W;
    localparam int RX_W    = SIZE_DATA + ADDR_W;
    localparam int DST_L   = SIZE_DATA;
    localparam int DST_Y   = DST_L + LOCAL_W;
    localparam int DST_X   = DST_Y + SIZE_Y;
    localparam int SX_DIFF = size_diff(SIZE_X);
    localparam int SY_DIFF = size_diff(SIZE_Y);

    if (RMI_MSG_SIZE != SIZE_DATA + 3 * ADDR_BYTE_W) begin : g_bad_msg_size
        $error("RMI_MSG_SIZE must equal SIZE_DATA + 24");
    end
    if (SX_DIFF < 0 || SY_DIFF < 0) begin : g_bad_coord_size
        $error("SIZE_X and SIZE_Y must fit in an address byte");
    end

    logic [0:0]              tx_acc_st, tx_snd_st, rx_rd_st, rx_dlv_st;
    logic                    tx_full, tx_empty, tx_acc, tx_pop;
    logic                    rx_full, rx_empty, rx_read, rx_push, rx_deliver, dst_ok;
    logic [RMI_MSG_SIZE-1:0] tx_head;
    logic [RX_W-1:0]         rx_wdata, rx_head;
    logic [ADDR_W-1:0]       orig_q;
    logic [15:0]             drop_cnt_q;
    logic                    unused_tx_bits;

    // ---------------- achannel -> NoC ----------------
    // A full FIFO still accepts when the send side pops on the same edge.
    assign tx_pop = !tx_empty && !wait_i && (tx_snd_st == ST_IDLE);
    assign tx_acc = tx_ch_lz_i && (tx_acc_st == ST_IDLE) && (!tx_full || tx_pop);

    rtsnoc_sync_fifo #(
        .WIDTH      (RMI_MSG_SIZE),
        .DEPTH_LOG2 (TX_DEPTH_LOG2)
    ) u_tx_fifo (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .push  (tx_acc),
        .wdata (tx_ch_z_i),
        .pop   (tx_pop),
        .full  (tx_full),
        .empty (tx_empty),
        .rdata (tx_head)
    );

    // Destination fields come from the low bits of each address byte; the
    // origin is captured with the pop so din_o stays fully registered.
    assign din_o = {orig_q,
                    tx_head[SIZE_DATA + MSG_X_OFS +: SIZE_X],
                    tx_head[SIZE_DATA + MSG_Y_OFS +: SIZE_Y],
                    tx_head[SIZE_DATA + MSG_L_OFS +: LOCAL_W],
                    tx_head[SIZE_DATA-1:0]};
    assign unused_tx_bits = ^tx_head;

    // ---------------- NoC -> achannel ----------------
    assign dst_ok = (dout_i[DST_X +: SIZE_X] == x) &&
                    (dout_i[DST_Y +: SIZE_Y] == y) &&
                    (dout_i[DST_L +: LOCAL_W] == local_addr);

    assign rx_deliver = !rx_empty && rx_ch_lz_i && (rx_dlv_st == ST_IDLE);
    assign rx_read    = nd_i && (rx_rd_st == ST_IDLE) && (!rx_full || rx_deliver);
    assign rx_push    = rx_read && (!CHECK_DST || dst_ok);
    assign rx_wdata   = {dout_i[BUS-1 -: ADDR_W], dout_i[SIZE_DATA-1:0]};

    rtsnoc_sync_fifo #(
        .WIDTH      (RX_W),
        .DEPTH_LOG2 (RX_DEPTH_LOG2)
    ) u_rx_fifo (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .push  (rx_push),
        .wdata (rx_wdata),
        .pop   (rx_deliver),
        .full  (rx_full),
        .empty (rx_empty),
        .rdata (rx_head)
    );

    // rx_head layout: {X_orig, Y_orig, local_orig, data}.
    assign rx_ch_z_o = {ADDR_BYTE_W'(rx_head[SIZE_DATA +: LOCAL_W]),
                        ADDR_BYTE_W'(rx_head[RX_W-1-SIZE_X -: SIZE_Y]),
                        ADDR_BYTE_W'(rx_head[RX_W-1 -: SIZE_X]),
                        rx_head[SIZE_DATA-1:0]};

    // ---------------- strobe FSMs and drop counter ----------------
    // Every accept condition requires ST_IDLE, so STROBE always lasts one cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tx_acc_st  <= ST_IDLE;
            tx_snd_st  <= ST_IDLE;
            rx_rd_st   <= ST_IDLE;
            rx_dlv_st  <= ST_IDLE;
            orig_q     <= '0;
            drop_cnt_q <= '0;
        end else begin
            tx_acc_st <= tx_acc     ? ST_STROBE : ST_IDLE;
            tx_snd_st <= tx_pop     ? ST_STROBE : ST_IDLE;
            rx_rd_st  <= rx_read    ? ST_STROBE : ST_IDLE;
            rx_dlv_st <= rx_deliver ? ST_STROBE : ST_IDLE;
            if (tx_pop) begin
                orig_q <= {x, y, local_addr};
            end
            if (rx_read && !rx_push && (drop_cnt_q != 16'hFFFF)) begin
                drop_cnt_q <= drop_cnt_q + 16'd1;
            end
        end
    end

    assign tx_ch_vz_o = (tx_acc_st == ST_STROBE);
    assign wr_o       = (tx_snd_st == ST_STROBE);
    assign rd_o       = (rx_rd_st  == ST_STROBE);
    assign rx_ch_vz_o = (rx_dlv_st == ST_STROBE);
    assign drop_cnt_o = drop_cnt_q;

endmodule

// File: tb/tb_rtsnoc_achannel_bridge.sv
// tb/tb_rtsnoc_achannel_bridge.sv - directed self-checking bench for rtsnoc_achannel_bridge
module tb_rtsnoc_achannel_bridge;

    typedef struct {
        logic [79:0] msg;
        logic [65:0] din;
    } tx_vec_t;

    typedef struct {
        logic [65:0] flit;
        logic [79:0] z;
    } rx_vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [65:0] din_o;
    logic        wr_o;
    logic        wait_i;
    logic [65:0] dout;
    logic        nd;
    logic        rd_o;
    logic [0:0]  own_x, own_y;
    logic [2:0]  own_l;
    logic [79:0] tx_ch_z;
    logic        tx_ch_lz;
    logic        tx_ch_vz_o;
    logic [79:0] rx_ch_z_o;
    logic        rx_lz;
    logic        rx_ch_vz_o;
    logic [15:0] drop_cnt_o;

    tx_vec_t     txv [6];
    rx_vec_t     rxv [6];
    logic [65:0] tx_bad [3];

    logic [79:0] tx_q [$];
    logic [65:0] rt_q [$];
    logic [65:0] wr_log [$];
    int          wr_cyc [$];
    logic [79:0] rx_log [$];

    int cyc = 0;
    int wr_cnt = 0, txv_cnt = 0, rd_cnt = 0, rxv_cnt = 0, dbl = 0;
    bit prev_txvz = 1'b0;
    int n_vec = 0, n_fail = 0;

    rtsnoc_achannel_bridge #(
        .CHECK_DST (1'b1)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .din_o      (din_o),
        .wr_o       (wr_o),
        .wait_i     (wait_i),
        .dout_i     (dout),
        .nd_i       (nd),
        .rd_o       (rd_o),
        .x          (own_x),
        .y          (own_y),
        .local_addr (own_l),
        .tx_ch_z_i  (tx_ch_z),
        .tx_ch_lz_i (tx_ch_lz),
        .tx_ch_vz_o (tx_ch_vz_o),
        .rx_ch_z_o  (rx_ch_z_o),
        .rx_ch_lz_i (rx_lz),
        .rx_ch_vz_o (rx_ch_vz_o),
        .drop_cnt_o (drop_cnt_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (wr_o) begin
            wr_cnt++;
            wr_log.push_back(din_o);
            wr_cyc.push_back(cyc);
        end
        if (tx_ch_vz_o) begin
            txv_cnt++;
            if (prev_txvz) dbl++;
        end
        prev_txvz = tx_ch_vz_o;
        if (rd_o) rd_cnt++;
        if (rx_ch_vz_o) begin
            rxv_cnt++;
            rx_log.push_back(rx_ch_z_o);
        end
    end

    function automatic logic [65:0] mk_flit(input bit xo, input bit yo, input logic [2:0] lo,
                                            input bit xd, input bit yd, input logic [2:0] ld,
                                            input logic [55:0] d);
        return {xo, yo, lo, xd, yd, ld, d};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive();
        tx_ch_lz = (tx_q.size() > 0);
        tx_ch_z  = (tx_q.size() > 0) ? tx_q[0] : '0;
        nd       = (rt_q.size() > 0);
        dout     = (rt_q.size() > 0) ? rt_q[0] : '0;
    endtask

    // Advance one cycle; the achannel source and the router model retire the
    // item that the DUT strobed on this edge and present the next one.
    task automatic step();
        @(posedge clk);
        #1;
        if (tx_ch_vz_o && tx_q.size() > 0) void'(tx_q.pop_front());
        if (rd_o && rt_q.size() > 0) void'(rt_q.pop_front());
        drive();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tx_q.delete();
        rt_q.delete();
        drive();
        step();
        rst = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, " din_o"}, din_o, 0);
        check({tag, " wr_o"}, wr_o, 0);
        check({tag, " rd_o"}, rd_o, 0);
        check({tag, " tx_vz"}, tx_ch_vz_o, 0);
        check({tag, " rx_vz"}, rx_ch_vz_o, 0);
        check({tag, " rx_z"}, rx_ch_z_o, 0);
        check({tag, " drop_cnt"}, drop_cnt_o, 0);
    endtask

    initial begin
        int b_wr, b_tv, b_rd, b_rv, b_wl, b_rl;

        txv[0] = '{{8'd2,   8'd1,   8'd0,   56'hA5},              mk_flit(0, 0, 3'd0, 0, 1, 3'd2, 56'hA5)};
        txv[1] = '{{8'd7,   8'd0,   8'd1,   56'h123456789ABCDE},  mk_flit(0, 0, 3'd0, 1, 0, 3'd7, 56'h123456789ABCDE)};
        txv[2] = '{{8'hFA,  8'hFF,  8'hFE,  56'hFFFFFFFFFFFFFF},  mk_flit(0, 0, 3'd0, 0, 1, 3'd2, 56'hFFFFFFFFFFFFFF)};
        txv[3] = '{{8'd5,   8'd3,   8'd3,   56'h0},               mk_flit(0, 0, 3'd0, 1, 1, 3'd5, 56'h0)};
        txv[4] = '{{8'd0,   8'd0,   8'd0,   56'h80000000000001},  mk_flit(0, 0, 3'd0, 0, 0, 3'd0, 56'h80000000000001)};
        txv[5] = '{{8'd1,   8'd2,   8'd1,   56'hDEADBEEF},        mk_flit(0, 0, 3'd0, 1, 0, 3'd1, 56'hDEADBEEF)};

        rxv[0] = '{mk_flit(1, 0, 3'd5, 0, 0, 3'd0, 56'h11),             {8'd5, 8'd0, 8'd1, 56'h11}};
        rxv[1] = '{mk_flit(0, 1, 3'd7, 0, 0, 3'd0, 56'hABCDEF),         {8'd7, 8'd1, 8'd0, 56'hABCDEF}};
        rxv[2] = '{mk_flit(1, 1, 3'd0, 0, 0, 3'd0, 56'hFFFFFFFFFFFFFF), {8'd0, 8'd1, 8'd1, 56'hFFFFFFFFFFFFFF}};
        rxv[3] = '{mk_flit(0, 0, 3'd2, 0, 0, 3'd0, 56'h5A5A),           {8'd2, 8'd0, 8'd0, 56'h5A5A}};
        rxv[4] = '{mk_flit(1, 1, 3'd7, 0, 0, 3'd0, 56'h0102030405),     {8'd7, 8'd1, 8'd1, 56'h0102030405}};
        rxv[5] = '{mk_flit(0, 1, 3'd1, 0, 0, 3'd0, 56'h77),             {8'd1, 8'd1, 8'd0, 56'h77}};

        tx_bad[0] = mk_flit(1, 1, 3'd1, 1, 0, 3'd0, 56'hB1);
        tx_bad[1] = mk_flit(1, 1, 3'd1, 0, 1, 3'd0, 56'hB2);
        tx_bad[2] = mk_flit(1, 1, 3'd1, 0, 0, 3'd3, 56'hB3);

        own_x = 1'b0; own_y = 1'b0; own_l = 3'd0;
        wait_i = 1'b0; rx_lz = 1'b0; rst = 1'b1;
        drive();
        step();
        step();
        check_zero("reset");
        rst = 1'b0;

        // Single TX: vz one edge after lz is sampled, wr the edge after.
        tx_q.push_back(txv[0].msg);
        drive();
        step();
        check("tx lat vz", tx_ch_vz_o, 1);
        check("tx lat wr early", wr_o, 0);
        step();
        check("tx lat wr", wr_o, 1);
        check("tx lat vz off", tx_ch_vz_o, 0);
        check("tx lat din", din_o, txv[0].din);

        // Single RX: rd on the nd sample edge, vz on the next.
        rx_lz = 1'b1;
        rt_q.push_back(rxv[0].flit);
        drive();
        step();
        check("rx lat rd", rd_o, 1);
        check("rx lat vz early", rx_ch_vz_o, 0);
        step();
        check("rx lat vz", rx_ch_vz_o, 1);
        check("rx lat z", rx_ch_z_o, rxv[0].z);
        step();

        // TX burst under back-pressure.
        do_reset();
        rx_lz = 1'b0;
        wait_i = 1'b1;
        b_wr = wr_cnt; b_tv = txv_cnt; b_wl = wr_log.size();
        for (int i = 0; i < 6; i++) tx_q.push_back(txv[i].msg);
        drive();
        repeat (20) step();
        check("burst vz while blocked", txv_cnt - b_tv, 4);
        check("burst wr while blocked", wr_cnt - b_wr, 0);
        wait_i = 1'b0;
        repeat (30) step();
        check("burst wr total", wr_cnt - b_wr, 6);
        check("burst vz total", txv_cnt - b_tv, 6);
        for (int i = 0; i < 6; i++) begin
            if (b_wl + i < wr_log.size()) begin
                check($sformatf("burst din[%0d]", i), wr_log[b_wl + i], txv[i].din);
                if (i > 0) check($sformatf("burst gap[%0d]", i), wr_cyc[b_wl + i] - wr_cyc[b_wl + i - 1], 2);
            end else begin
                check($sformatf("burst missing[%0d]", i), 0, 1);
            end
        end

        // RX back-pressure, then a read and a deliver on the same edge.
        do_reset();
        rx_lz = 1'b0;
        b_rd = rd_cnt; b_rv = rxv_cnt; b_rl = rx_log.size();
        for (int i = 0; i < 6; i++) rt_q.push_back(rxv[i].flit);
        drive();
        repeat (20) step();
        check("rx bp reads", rd_cnt - b_rd, 4);
        check("rx bp delivers", rxv_cnt - b_rv, 0);
        rx_lz = 1'b1;
        step();
        check("simul rd", rd_o, 1);
        check("simul vz", rx_ch_vz_o, 1);
        check("simul z", rx_ch_z_o, rxv[0].z);
        rx_lz = 1'b0;
        repeat (10) step();
        check("simul still full", rd_cnt - b_rd, 5);
        rx_lz = 1'b1;
        repeat (30) step();
        check("rx drain reads", rd_cnt - b_rd, 6);
        check("rx drain delivers", rxv_cnt - b_rv, 6);
        for (int i = 0; i < 6; i++) begin
            if (b_rl + i < rx_log.size()) check($sformatf("rx order[%0d]", i), rx_log[b_rl + i], rxv[i].z);
            else check($sformatf("rx missing[%0d]", i), 0, 1);
        end

        // Destination filter and drop counter saturation.
        do_reset();
        rx_lz = 1'b1;
        b_rd = rd_cnt; b_rv = rxv_cnt; b_rl = rx_log.size();
        for (int i = 0; i < 3; i++) rt_q.push_back(tx_bad[i]);
        rt_q.push_back(rxv[1].flit);
        drive();
        repeat (20) step();
        check("filter drops", drop_cnt_o, 3);
        check("filter delivers", rxv_cnt - b_rv, 1);
        check("filter reads", rd_cnt - b_rd, 4);
        if (b_rl < rx_log.size()) check("filter z", rx_log[b_rl], rxv[1].z);
        else check("filter z missing", 0, 1);
        force dut.drop_cnt_q = 16'hFFFF;
        step();
        release dut.drop_cnt_q;
        rt_q.push_back(tx_bad[0]);
        drive();
        repeat (8) step();
        check("drop saturate", drop_cnt_o, 16'hFFFF);
        check("drop sat delivers", rxv_cnt - b_rv, 1);

        // Reset with both FIFOs half full.
        wait_i = 1'b0;
        tx_q.push_back(txv[1].msg);
        drive();
        repeat (6) step();
        check("pre-reset din", din_o, txv[1].din);
        wait_i = 1'b1;
        rx_lz = 1'b0;
        tx_q.push_back(txv[2].msg);
        tx_q.push_back(txv[3].msg);
        rt_q.push_back(rxv[2].flit);
        rt_q.push_back(rxv[3].flit);
        drive();
        repeat (8) step();
        rst = 1'b1;
        step();
        check_zero("mid reset");
        rst = 1'b0;
        tx_q.delete();
        rt_q.delete();
        wait_i = 1'b0;
        rx_lz = 1'b1;
        drive();
        b_wr = wr_cnt; b_rv = rxv_cnt;
        repeat (15) step();
        check("post-reset wr", wr_cnt - b_wr, 0);
        check("post-reset rx vz", rxv_cnt - b_rv, 0);

        check("tx vz back-to-back", dbl, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
